// File: rtl/mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler
//
// Purpose: arbitrates 16 requesters for one shared 16:1 single-bit mux.
// A granted requester keeps the mux for up to HOLD_BEATS accepted beats, or
// until it drops its request, after which the next requester (searching
// upward from the one after the last grant, wrapping 15->0) is granted.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   req[15:0]  request vector, bit i = requester i wants the mux
//   in[15:0]   mux data inputs, bit i belongs to requester i
//   out_ready  downstream accepts the current beat
//   sel[3:0]   registered select for the shared mux (granted index)
//   gnt[15:0]  registered one-hot grant, all-zero when nothing is granted
//   out_bit    in[sel] while out_valid, else 0 (combinational)
//   out_valid  beat valid, high only while transferring
//   busy       high while arbitrating or transferring
//
// Parameter:
//   HOLD_BEATS max accepted beats per grant, legal range 1..16
//
// Configuration macro:
//   MUX_SCHED_FIXED_PRIO_EN  when defined, arbitration always grants the
//                            lowest-index requester and the round-robin
//                            pointer is not built.
// ---------------------------------------------------------------------------
module mux_rr_scheduler #(
    parameter int HOLD_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] in,
    input  logic        out_ready,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        out_bit,
    output logic        out_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  sel_reg, sel_next;
    logic [15:0] gnt_reg, gnt_next;
    logic [4:0]  beat_cnt_reg, beat_cnt_next;

    logic [3:0]  search_base;
    logic [15:0] rot_req;
    logic [3:0]  rot_idx;
    logic [3:0]  win_idx;
    logic [15:0] win_onehot;
    logic        beat_acc;
    logic [4:0]  beat_cnt_inc;
    logic        hold_done;
    logic        release_now;

`ifdef MUX_SCHED_FIXED_PRIO_EN
    // Fixed priority: the search always begins at requester 0.
    assign search_base = 4'd0;
`else
    // Round-robin pointer: index where the next search begins.
    logic [3:0] ptr_reg, ptr_next;
    assign search_base = ptr_reg;
`endif

    // Rotate the request vector so the search start lands on bit 0; the
    // 4-bit index addition wraps 15->0 naturally.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rot
            assign rot_req[gi] = req[4'(gi) + search_base];
        end
    endgenerate

    // Lowest set bit of the rotated vector (loop runs downward so the
    // lowest index is the last, winning assignment).
    always_comb begin
        rot_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_idx = 4'(i);
            end
        end
    end

    // Undo the rotation to get the absolute requester index.
    assign win_idx = rot_idx + search_base;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == 4'(gi));
        end
    endgenerate

    assign out_valid    = (state_reg == XFER);
    assign busy         = (state_reg != IDLE);
    assign out_bit      = out_valid & in[sel_reg];
    assign sel          = sel_reg;
    assign gnt          = gnt_reg;

    assign beat_acc     = out_valid & out_ready;
    assign beat_cnt_inc = beat_cnt_reg + {4'd0, beat_acc};
    assign hold_done    = beat_acc && (beat_cnt_inc == 5'(HOLD_BEATS));
    // A dropped request releases immediately; if a beat was accepted in the
    // same cycle it still counts (beat_cnt_inc already includes it).
    assign release_now  = out_valid && (hold_done || !req[sel_reg]);

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        gnt_next      = gnt_reg;
        beat_cnt_next = beat_cnt_reg;
`ifdef MUX_SCHED_FIXED_PRIO_EN
`else
        ptr_next      = ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (|req) begin
                    sel_next      = win_idx;
                    gnt_next      = win_onehot;
                    beat_cnt_next = 5'd0;
                    state_next    = XFER;
                end else begin
                    gnt_next   = 16'd0;
                    state_next = IDLE;
                end
            end
            XFER: begin
                // out_ready low leaves beat_cnt_inc equal to beat_cnt_reg,
                // so sel/gnt/beat_cnt all hold during backpressure.
                beat_cnt_next = beat_cnt_inc;
                if (release_now) begin
`ifdef MUX_SCHED_FIXED_PRIO_EN
`else
                    ptr_next = sel_reg + 4'd1;
`endif
                    gnt_next   = 16'd0;
                    // Only other requesters justify going straight back to
                    // arbitration; the releasing one waits for IDLE.
                    state_next = (|(req & ~gnt_reg)) ? ARB : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sel_reg      <= 4'd0;
            gnt_reg      <= 16'd0;
            beat_cnt_reg <= 5'd0;
`ifdef MUX_SCHED_FIXED_PRIO_EN
`else
            ptr_reg      <= 4'd0;
`endif
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            gnt_reg      <= gnt_next;
            beat_cnt_reg <= beat_cnt_next;
`ifdef MUX_SCHED_FIXED_PRIO_EN
`else
            ptr_reg      <= ptr_next;
`endif
        end
    end

endmodule

// File: doc/mux_rr_scheduler.md
MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

Interface
REQ-001 SHALL have parameter: HOLD_BEATS, default 4, max accepted beats per grant; legal range 1..16.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req  input  16  request vector; bit i = requester i wants the shared 16:1 mux.
REQ-005 SHALL have port: in  input  16  mux data inputs; bit i belongs to requester i.
REQ-006 SHALL have port: out_ready  input  1  downstream accepts the current beat.
REQ-007 SHALL have port: sel  output  4  select driven to the shared 16:1 mux; equals the granted index.
REQ-008 SHALL have port: gnt  output  16  one-hot grant; all-zero when no grant.
REQ-009 SHALL have port: out_bit  output  1  in[sel] while out_valid; 0 otherwise (combinational).
REQ-010 SHALL have port: out_valid  output  1  beat valid; high only in XFER.
REQ-011 SHALL have port: busy  output  1  high in ARB or XFER.

Function
REQ-012 SHALL implement FSM states IDLE, ARB, XFER (registered state, registered sel/gnt).
REQ-013 IDLE: if |req then next state ARB; else remain IDLE.
REQ-014 ARB: SHALL grant the first set bit of req searching upward from ptr, wrapping 15->0; load sel with that index, gnt with its one-hot, clear beat_cnt, go XFER; if req is all-zero in this cycle, return to IDLE with gnt=0.
REQ-015 XFER: a beat is accepted in a cycle where out_valid & out_ready; each accepted beat increments beat_cnt.
REQ-016 XFER SHALL release the grant when the accepted beat makes beat_cnt reach HOLD_BEATS, or when req[sel]=0 (abort, regardless of out_ready).
REQ-017 On release: ptr <= sel+1 mod 16 (15 wraps to 0); gnt <= 0; next state ARB if |(req & ~gnt) else IDLE.
REQ-018 Simultaneous req[sel] drop and accepted beat: the beat counts as transferred, release occurs in the same cycle.
REQ-019 out_ready low in XFER SHALL hold sel, gnt, beat_cnt unchanged (no timeout).
REQ-020 Grant latency: req asserted in IDLE at cycle N yields gnt valid and out_valid high in cycle N+2.
REQ-021 sel SHALL not change while out_valid is high; gnt SHALL be one-hot or zero at all times.

Reset
REQ-022 rst_n low at a clock edge SHALL force state IDLE, ptr=0, beat_cnt=0, sel=0, gnt=0, out_valid=0, busy=0, out_bit=0, including mid-XFER (in-flight burst dropped).
REQ-023 First arbitration after reset SHALL start the search from index 0.

Configuration
REQ-024 Macro MUX_SCHED_FIXED_PRIO_EN: when defined, ARB SHALL always grant the lowest-index set req bit and ptr is unused; when undefined, round-robin per REQ-014/REQ-017.

Verification
REQ-025 Reset then req=16'h0001, out_ready=1, in=16'h0001, HOLD_BEATS=4 -> gnt=16'h0001, sel=0, out_bit=1 for 4 beats, then re-grant index 0 after one ARB cycle.
REQ-026 req=16'h0204 held, out_ready=1 -> grants alternate sel=2, sel=9, sel=2, each 4 beats (round-robin); with MUX_SCHED_FIXED_PRIO_EN -> sel=2 every grant.
REQ-027 Wrap: finish grant at sel=15 with req=16'h8001 -> next grant sel=0, ptr wraps to 0.
REQ-028 Backpressure: grant sel=5, out_ready=0 for 6 cycles -> out_valid=1, sel=5, beat_cnt frozen; on out_ready=1 remaining beats complete.
REQ-029 Abort: grant sel=10 after 2 beats, drop req[10] with out_ready=1 -> that beat counted, gnt=0 next cycle, ptr=11.
REQ-030 Reset mid-XFER (sel=7, beat_cnt=2) -> next cycle all outputs 0, state IDLE, next grant searched from 0.
